// File: rtl/spi_xform_slave.sv
// SPI slave device model: receives a DATA_W-bit word MSB-first, then replies with
// a bit-reversed / echoed / inverted copy over the next DATA_W sck periods.
module spi_xform_slave #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CPOL   = 0,
    parameter int unsigned CPHA   = 0,
    parameter int unsigned FCNT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sck,
    input  logic              ss,
    input  logic              mosi,
    input  logic [1:0]        op,
    output logic              miso,
    output logic              busy,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic IDLE_LVL = 1'(CPOL);

    typedef enum logic [1:0] {S_IDLE, S_RX, S_TX} state_e;

    logic sck_meta_q, sck_sync_q, sck_prev_q;
    logic ss_meta_q, ss_sync_q;
    logic mosi_meta_q, mosi_sync_q;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0]   shreg_q, shreg_d;
    logic [DATA_W-1:0]   txreg_q, txreg_d;
    logic                miso_q, miso_d;
    logic                busy_q, busy_d;
    logic                rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;

    logic                lead_c, trail_c, sample_c, shift_c;
    logic [DATA_W-1:0]   rx_word_c;

    function automatic logic [DATA_W-1:0] xform(input logic [1:0] sel,
                                                input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] rev;
        for (int unsigned i = 0; i < DATA_W; i++) rev[i] = w[DATA_W-1-i];
        case (sel)
            2'b00:   xform = rev;
            2'b01:   xform = w;
            2'b10:   xform = ~w;
            default: xform = ~rev;
        endcase
    endfunction

    // Edges are judged on the synchronised sck against its previous value.
    assign lead_c    = (sck_sync_q != IDLE_LVL) && (sck_prev_q == IDLE_LVL);
    assign trail_c   = (sck_sync_q == IDLE_LVL) && (sck_prev_q != IDLE_LVL);
    assign sample_c  = (CPHA == 0) ? lead_c : trail_c;
    assign shift_c   = (CPHA == 0) ? trail_c : lead_c;
    assign rx_word_c = {shreg_q, mosi_sync_q};

    always_ff @(posedge clock) begin
        if (reset) begin
            sck_meta_q  <= IDLE_LVL;
            sck_sync_q  <= IDLE_LVL;
            sck_prev_q  <= IDLE_LVL;
            ss_meta_q   <= 1'b1;
            ss_sync_q   <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            txreg_q     <= '0;
            miso_q      <= 1'b1;
            busy_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            sck_meta_q  <= sck;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            ss_meta_q   <= ss;
            ss_sync_q   <= ss_meta_q;
            mosi_meta_q <= mosi;
            mosi_sync_q <= mosi_meta_q;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            txreg_q     <= txreg_d;
            miso_q      <= miso_d;
            busy_q      <= busy_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next-state logic; ss deassertion takes priority over any sck edge.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        txreg_d     = txreg_q;
        miso_d      = miso_q;
        rx_valid_d  = 1'b0;
        rx_data_d   = rx_data_q;
        frame_cnt_d = frame_cnt_q;

        if (state_q != S_IDLE && ss_sync_q) begin
            state_d   = S_IDLE;
            miso_d    = 1'b1;
            shreg_d   = '0;
            bit_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (!ss_sync_q) begin
                        state_d   = S_RX;
                        bit_cnt_d = '0;
                    end
                end
                S_RX: begin
                    if (sample_c) begin
                        shreg_d = rx_word_c[DATA_W-2:0];
                        if (bit_cnt_q == LAST_BIT) begin
                            rx_data_d  = rx_word_c;
                            rx_valid_d = 1'b1;
                            txreg_d    = xform(op, rx_word_c);
                            bit_cnt_d  = '0;
                            state_d    = S_TX;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end else if (shift_c) begin
                        miso_d = 1'b1;
                    end
                end
                S_TX: begin
                    // txreg shifts left per sample edge, so its MSB is always the next bit.
                    if (shift_c) miso_d = txreg_q[DATA_W-1];
                    if (sample_c) begin
                        txreg_d = {txreg_q[DATA_W-2:0], 1'b0};
                        if (bit_cnt_q == LAST_BIT) begin
                            frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                            bit_cnt_d   = '0;
                            state_d     = S_RX;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    assign miso      = miso_q;
    assign busy      = busy_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign frame_cnt = frame_cnt_q;

endmodule
